pwm_timebase: RTL and testbench
===============================

Name: pwm_timebase

Overview:
- Centre-aligned timebase and sequencer for three per-phase dead-time PWM channels.
- Generates the shared up/down count `cnt` and the double-buffered `comp1`/`comp2` pairs for phases A, B and C.
- Drives the shared `brake` line, with fault latching and a controlled start/stop.
- Sits between the FOC core, which pushes new compare sets through a valid/ready handshake, and the three PWM channel instances.

Parameters:
- PWM_WIDTH, 16, width of counter, period and compare values.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- en  in  1  run request; level-sensitive.
- cfg_valid  in  1  new configuration set offered.
- cfg_ready  out  1  pending buffer empty; set accepted on cfg_valid&&cfg_ready.
- cfg_period  in  PWM_WIDTH  new half-period (peak count).
- cfg_comp1_a/b/c  in  PWM_WIDTH each  new comp1 per phase.
- cfg_comp2_a/b/c  in  PWM_WIDTH each  new comp2 per phase.
- fault_in  in  1  asynchronous external fault, active-high.
- fault_clr  in  1  fault clear request, single-cycle.
- cnt  out  PWM_WIDTH  shared counter to PWM channels.
- comp1_a/b/c, comp2_a/b/c  out  PWM_WIDTH each  active (shadow) compares.
- brake  out  1  forces all channels off.
- dir  out  1  0 = counting up, 1 = counting down.
- zero_pulse  out  1  high in the cycle where cnt==0 in RUN/STOP.
- peak_pulse  out  1  high in the cycle where cnt==active period; also serves as ADC trigger.
- update_done  out  1  one-cycle pulse when pending set is copied to shadow.
- fault_active  out  1  fault latched.

Behaviour:
- **Reset values (async, rstn=0):** cnt=0, dir=0, all comps=0, active period=0, pending empty, cfg_ready=1, brake=1, all pulses 0, fault_active=0, state IDLE.
- **fault_in** passes through a 2-flop synchroniser (fault_s). Latency fault_in→brake is ≤3 cycles.
- **Handshake:** a set is accepted on cfg_valid&&cfg_ready into the pending buffer. cfg_ready drops the next cycle and stays low until the pending set is applied.
- **Effective period:** per_eff = max(active period, 2).
- **FSM states:** IDLE, RUN, STOP, FAULT.
  - IDLE: brake=1, cnt=0, dir=0. If fault_s → FAULT. Else if en → RUN; on this transition a pending set, if any, is applied immediately (update_done pulse).
  - RUN: brake=0.
    - Up phase: cnt increments. In the cycle cnt==per_eff, set dir=1 and assert peak_pulse; the next cnt is per_eff-1.
    - Down phase: cnt decrements. In the cycle cnt==0, set dir=0 and assert zero_pulse; the next cnt is 1.
    - Sequence for per_eff=4: 0,1,2,3,4,3,2,1,0,1…; period is 2*per_eff cycles.
    - Valley update: in a cycle with cnt==0 and pending full, copy period and all six comps to the shadow registers. New values appear on outputs the next cycle; update_done pulses; cfg_ready returns to 1 the next cycle.
    - A set accepted in the same valley cycle is applied at the following valley, not the current one.
    - en=0 → STOP.
  - STOP: counting continues unchanged.
    - en=1 before the valley → RUN, with no glitch in cnt.
    - Otherwise, at cnt==0 (valley update still performed) → IDLE the next cycle.
  - FAULT is entered from any state when fault_s=1.
    - On entry: brake=1 the same cycle the state register changes, cnt=0, dir=0, fault_active=1.
    - Pending and shadow registers are preserved.
    - Exit to IDLE only when fault_clr=1 and fault_s=0. fault_clr is ignored while fault_s=1 (fault wins).
- **Priority:** fault > en/stop > valley update.
- **Compare values** are passed through unclamped. comp > per_eff is legal, meaning the compare never matches in that cycle.
- **Period changes** take effect only at the valley, never mid-cycle.

Decomposition:
- Package pwm_pkg holds the state encodings (IDLE=0, RUN=1, STOP=2, FAULT=3) and a typedef for the comp set (period + 6 compares), shared with the PWM channel tests.
- One sub-module: pwm_updown_cnt (counter, dir, peak/zero detect, per_eff clamp).
- Synchroniser, FSM and buffers stay in the top.

Test Plan:
- Start, period=4, comps A=(1,3): reset, push set, en=1 → cnt 0,1,2,3,4,3,2,1,0,1…; peak_pulse at cnt=4; zero_pulse at cnt=0; update_done on RUN entry.
- Shadow update, mid-cycle push period=6 while cnt=2 rising → old period 4 finishes; new comps/period visible the cycle after cnt==0; cfg_ready low from accept until one cycle after update_done.
- Back-to-back sets: a second cfg_valid while pending is full → not accepted (cfg_ready=0); accept occurring in a valley cycle → applied one full period (8 cycles) later.
- Stop/restart: en=0 at cnt=3 up → counting continues to 0, then IDLE with brake=1; a second run with en=1 again at cnt=2 down in STOP → stays RUN, brake never asserts.
- Fault: fault_in=1 at cnt=2 → brake=1 and cnt=0 within 3 cycles; fault_clr while fault_in=1 → stays FAULT; after fault_in=0 plus 2 cycles, fault_clr → IDLE; en=1 → RUN with the preserved comps.
- Boundary: period=0 or 1 → counts 0,1,2,1,0 (per_eff=2); async rstn pulse mid-RUN → all outputs at reset values immediately, pending discarded.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: timebase state encoding and compare-set type shared with the PWM channels
package pwm_pkg;
  localparam int PWM_W = 16;
  localparam int PER_MIN = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2, FAULT = 2'd3} state_t;
  typedef struct packed {
    logic [PWM_W-1:0] period;
    logic [PWM_W-1:0] comp1_a, comp1_b, comp1_c;
    logic [PWM_W-1:0] comp2_a, comp2_b, comp2_c;
  } comp_set_t;
endpackage

// File: rtl/pwm_timebase_if.sv
// pwm_timebase_if: compare-set valid/ready handshake from the FOC core to the timebase
interface pwm_timebase_if #(parameter int PWM_WIDTH = pwm_pkg::PWM_W);
  logic cfg_valid, cfg_ready;
  logic [PWM_WIDTH-1:0] cfg_period;
  logic [PWM_WIDTH-1:0] cfg_comp1_a, cfg_comp1_b, cfg_comp1_c;
  logic [PWM_WIDTH-1:0] cfg_comp2_a, cfg_comp2_b, cfg_comp2_c;
  modport master (
    output cfg_valid, cfg_period, cfg_comp1_a, cfg_comp1_b, cfg_comp1_c,
    output cfg_comp2_a, cfg_comp2_b, cfg_comp2_c,
    input  cfg_ready
  );
  modport slave (
    input  cfg_valid, cfg_period, cfg_comp1_a, cfg_comp1_b, cfg_comp1_c,
    input  cfg_comp2_a, cfg_comp2_b, cfg_comp2_c,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_updown_cnt.sv
// pwm_updown_cnt: centre-aligned up/down counter with peak/valley decode
module pwm_updown_cnt import pwm_pkg::*; #(
  parameter int PWM_WIDTH = PWM_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 run,
  input  logic                 act,
  input  logic [PWM_WIDTH-1:0] per,
  output logic [PWM_WIDTH-1:0] cnt,
  output logic                 dir,
  output logic                 peak,
  output logic                 zero
);
  logic [PWM_WIDTH-1:0] per_eff;
  always_comb per_eff = (per < PWM_WIDTH'(PER_MIN)) ? PWM_WIDTH'(PER_MIN) : per;
  assign peak = act && cnt == per_eff;
  assign zero = act && cnt == '0;
  // dir is computed one step ahead so it already reads 1 at the peak and 0 at the valley
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt <= '0;
      dir <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      dir <= 1'b0;
    end else if (!dir) begin
      cnt <= cnt + PWM_WIDTH'(1);
      dir <= cnt + PWM_WIDTH'(1) >= per_eff;
    end else begin
      cnt <= cnt - PWM_WIDTH'(1);
      dir <= cnt > PWM_WIDTH'(1);
    end
endmodule

// File: rtl/pwm_timebase.sv
// pwm_timebase: centre-aligned timebase, compare double-buffering and run/stop/fault sequencing
module pwm_timebase import pwm_pkg::*; #(
  parameter int PWM_WIDTH = PWM_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  pwm_timebase_if.slave        cfg,
  input  logic                 fault_in,
  input  logic                 fault_clr,
  output logic [PWM_WIDTH-1:0] cnt,
  output logic [PWM_WIDTH-1:0] comp1_a,
  output logic [PWM_WIDTH-1:0] comp1_b,
  output logic [PWM_WIDTH-1:0] comp1_c,
  output logic [PWM_WIDTH-1:0] comp2_a,
  output logic [PWM_WIDTH-1:0] comp2_b,
  output logic [PWM_WIDTH-1:0] comp2_c,
  output logic                 brake,
  output logic                 dir,
  output logic                 zero_pulse,
  output logic                 peak_pulse,
  output logic                 update_done,
  output logic                 fault_active
);
  state_t state, nxt;
  logic [1:0] fsync;
  logic fault_s, full, act, go, upd;
  logic [6:0][PWM_WIDTH-1:0] pend, shad;
  assign fault_s = fsync[1];
  assign act = state == RUN || state == STOP;
  always_comb
    nxt = fault_s ? FAULT :
          state == IDLE ? (en ? RUN : IDLE) :
          state == RUN  ? (en ? RUN : STOP) :
          state == STOP ? (en ? RUN : (zero_pulse ? IDLE : STOP)) :
          (fault_clr ? IDLE : FAULT);
  assign go = nxt == RUN || nxt == STOP;
  // a pending set lands at every valley, or straight away when leaving IDLE
  assign upd = full && !fault_s && (act ? zero_pulse : (state == IDLE && en));
  assign cfg.cfg_ready = !full;
  assign {comp2_c, comp2_b, comp2_a, comp1_c, comp1_b, comp1_a} = shad[6:1];
  pwm_updown_cnt #(.PWM_WIDTH(PWM_WIDTH)) u_cnt (
    .clk  (clk),
    .rstn (rstn),
    .run  (act && go),
    .act  (act),
    .per  (shad[0]),
    .cnt  (cnt),
    .dir  (dir),
    .peak (peak_pulse),
    .zero (zero_pulse)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      fsync        <= '0;
      state        <= IDLE;
      brake        <= 1'b1;
      fault_active <= 1'b0;
      update_done  <= 1'b0;
      full         <= 1'b0;
      pend         <= '0;
      shad         <= '0;
    end else begin
      fsync        <= {fsync[0], fault_in};
      state        <= nxt;
      brake        <= !go;
      fault_active <= nxt == FAULT;
      update_done  <= upd;
      if (cfg.cfg_valid && !full) begin
        pend <= {cfg.cfg_comp2_c, cfg.cfg_comp2_b, cfg.cfg_comp2_a,
                 cfg.cfg_comp1_c, cfg.cfg_comp1_b, cfg.cfg_comp1_a, cfg.cfg_period};
        full <= 1'b1;
      end else if (upd) full <= 1'b0;
      if (upd) shad <= pend;
    end
endmodule

// File: tb/tb_pwm_timebase.sv
// tb_pwm_timebase: directed vector table plus hand-written fault, boundary and reset sequences
module tb_pwm_timebase;
  logic clk = 0, rstn = 0, en = 0, fault_in = 0, fault_clr = 0;
  logic [15:0] cnt, comp1_a, comp1_b, comp1_c, comp2_a, comp2_b, comp2_c;
  logic brake, dir, zero_pulse, peak_pulse, update_done, fault_active;
  int n_chk = 0, n_fail = 0;
  int seq_c[5] = '{2, 1, 0, 1, 2};
  int seq_p[5] = '{1, 0, 0, 0, 1};
  int seq_d[5] = '{1, 1, 0, 0, 1};

  pwm_timebase_if #(.PWM_WIDTH(16)) cfg ();
  pwm_timebase #(.PWM_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .en(en), .cfg(cfg), .fault_in(fault_in), .fault_clr(fault_clr),
    .cnt(cnt), .comp1_a(comp1_a), .comp1_b(comp1_b), .comp1_c(comp1_c),
    .comp2_a(comp2_a), .comp2_b(comp2_b), .comp2_c(comp2_c), .brake(brake), .dir(dir),
    .zero_pulse(zero_pulse), .peak_pulse(peak_pulse), .update_done(update_done),
    .fault_active(fault_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, val;
    logic [15:0] per, c1, c2, ecnt;
    logic edir, ebrk, ezero, epeak, eupd, erdy;
    logic [15:0] ec1, ec2;
  } vec_t;
  vec_t vt[$];

  function automatic void add(input logic en_i, input logic val, input logic [15:0] per,
                              input logic [15:0] c1, input logic [15:0] c2, input logic [15:0] ecnt,
                              input logic edir, input logic ebrk, input logic ezero,
                              input logic epeak, input logic eupd, input logic erdy,
                              input logic [15:0] ec1, input logic [15:0] ec2);
    vt.push_back('{en_i, val, per, c1, c2, ecnt, edir, ebrk, ezero, epeak, eupd, erdy, ec1, ec2});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_comps(input string nm, input logic [15:0] e1, input logic [15:0] e2);
    chk({nm, "_c1a"}, comp1_a, e1);
    chk({nm, "_c1b"}, comp1_b, 16'(e1 * 3));
    chk({nm, "_c1c"}, comp1_c, 16'(e1 * 5));
    chk({nm, "_c2a"}, comp2_a, e2);
    chk({nm, "_c2b"}, comp2_b, 16'(e2 * 3));
    chk({nm, "_c2c"}, comp2_c, 16'(e2 * 5));
  endtask

  task automatic drive(input logic v, input logic [15:0] p, input logic [15:0] c1, input logic [15:0] c2);
    cfg.cfg_valid = v;
    cfg.cfg_period = p;
    cfg.cfg_comp1_a = c1;
    cfg.cfg_comp1_b = 16'(c1 * 3);
    cfg.cfg_comp1_c = 16'(c1 * 5);
    cfg.cfg_comp2_a = c2;
    cfg.cfg_comp2_b = 16'(c2 * 3);
    cfg.cfg_comp2_c = 16'(c2 * 5);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_upd(input string nm);
    int k = 0;
    while (!update_done && k < 20) begin
      step();
      k++;
    end
    chk(nm, update_done, 1);
  endtask

  task automatic chk_seq(input string nm);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("%s_cnt%0d", nm, i), cnt, seq_c[i]);
      chk($sformatf("%s_peak%0d", nm, i), peak_pulse, seq_p[i]);
      chk($sformatf("%s_dir%0d", nm, i), dir, seq_d[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // en val per c1 c2 | cnt dir brk zero peak upd rdy | c1 c2
    add(0,1,4,1,3, 0,0,1,0,0,0,0, 0,0);
    add(1,0,0,0,0, 0,0,0,1,0,1,1, 1,3);
    add(1,0,0,0,0, 1,0,0,0,0,0,1, 1,3);
    add(1,0,0,0,0, 2,0,0,0,0,0,1, 1,3);
    add(1,1,6,2,5, 3,0,0,0,0,0,0, 1,3);
    add(1,0,0,0,0, 4,1,0,0,1,0,0, 1,3);
    add(1,0,0,0,0, 3,1,0,0,0,0,0, 1,3);
    add(1,1,9,9,9, 2,1,0,0,0,0,0, 1,3);
    add(1,0,0,0,0, 1,1,0,0,0,0,0, 1,3);
    add(1,0,0,0,0, 0,0,0,1,0,0,0, 1,3);
    add(1,0,0,0,0, 1,0,0,0,0,1,1, 2,5);
    add(1,0,0,0,0, 2,0,0,0,0,0,1, 2,5);
    add(1,0,0,0,0, 3,0,0,0,0,0,1, 2,5);
    add(1,0,0,0,0, 4,0,0,0,0,0,1, 2,5);
    add(1,0,0,0,0, 5,0,0,0,0,0,1, 2,5);
    add(1,0,0,0,0, 6,1,0,0,1,0,1, 2,5);
    add(1,0,0,0,0, 5,1,0,0,0,0,1, 2,5);
    add(1,0,0,0,0, 4,1,0,0,0,0,1, 2,5);
    add(1,0,0,0,0, 3,1,0,0,0,0,1, 2,5);
    add(1,0,0,0,0, 2,1,0,0,0,0,1, 2,5);
    add(1,0,0,0,0, 1,1,0,0,0,0,1, 2,5);
    add(1,0,0,0,0, 0,0,0,1,0,0,1, 2,5);
    add(1,1,4,3,7, 1,0,0,0,0,0,0, 2,5);
    add(1,0,0,0,0, 2,0,0,0,0,0,0, 2,5);
    add(1,0,0,0,0, 3,0,0,0,0,0,0, 2,5);
    add(1,0,0,0,0, 4,0,0,0,0,0,0, 2,5);
    add(1,0,0,0,0, 5,0,0,0,0,0,0, 2,5);
    add(1,0,0,0,0, 6,1,0,0,1,0,0, 2,5);
    add(1,0,0,0,0, 5,1,0,0,0,0,0, 2,5);
    add(1,0,0,0,0, 4,1,0,0,0,0,0, 2,5);
    add(1,0,0,0,0, 3,1,0,0,0,0,0, 2,5);
    add(1,0,0,0,0, 2,1,0,0,0,0,0, 2,5);
    add(1,0,0,0,0, 1,1,0,0,0,0,0, 2,5);
    add(1,0,0,0,0, 0,0,0,1,0,0,0, 2,5);
    add(1,0,0,0,0, 1,0,0,0,0,1,1, 3,7);
    add(1,0,0,0,0, 2,0,0,0,0,0,1, 3,7);
    add(1,0,0,0,0, 3,0,0,0,0,0,1, 3,7);
    add(0,0,0,0,0, 4,1,0,0,1,0,1, 3,7);
    add(0,0,0,0,0, 3,1,0,0,0,0,1, 3,7);
    add(0,0,0,0,0, 2,1,0,0,0,0,1, 3,7);
    add(0,0,0,0,0, 1,1,0,0,0,0,1, 3,7);
    add(0,0,0,0,0, 0,0,0,1,0,0,1, 3,7);
    add(0,0,0,0,0, 0,0,1,0,0,0,1, 3,7);
    add(0,0,0,0,0, 0,0,1,0,0,0,1, 3,7);
    add(1,0,0,0,0, 0,0,0,1,0,0,1, 3,7);
    add(1,0,0,0,0, 1,0,0,0,0,0,1, 3,7);
    add(1,0,0,0,0, 2,0,0,0,0,0,1, 3,7);
    add(1,0,0,0,0, 3,0,0,0,0,0,1, 3,7);
    add(1,0,0,0,0, 4,1,0,0,1,0,1, 3,7);
    add(1,0,0,0,0, 3,1,0,0,0,0,1, 3,7);
    add(0,0,0,0,0, 2,1,0,0,0,0,1, 3,7);
    add(1,0,0,0,0, 1,1,0,0,0,0,1, 3,7);
    add(1,0,0,0,0, 0,0,0,1,0,0,1, 3,7);
    add(1,0,0,0,0, 1,0,0,0,0,0,1, 3,7);

    drive(0, 0, 0, 0);
    step();
    chk("rst_cnt", cnt, 0);
    chk("rst_dir", dir, 0);
    chk("rst_brake", brake, 1);
    chk("rst_ready", cfg.cfg_ready, 1);
    chk("rst_zero", zero_pulse, 0);
    chk("rst_peak", peak_pulse, 0);
    chk("rst_upd", update_done, 0);
    chk("rst_fault", fault_active, 0);
    chk_comps("rst", 0, 0);
    rstn = 1;

    for (int i = 0; i < vt.size(); i++) begin
      en = vt[i].en;
      drive(vt[i].val, vt[i].per, vt[i].c1, vt[i].c2);
      step();
      chk($sformatf("v%0d_cnt", i), cnt, vt[i].ecnt);
      chk($sformatf("v%0d_dir", i), dir, vt[i].edir);
      chk($sformatf("v%0d_brake", i), brake, vt[i].ebrk);
      chk($sformatf("v%0d_zero", i), zero_pulse, vt[i].ezero);
      chk($sformatf("v%0d_peak", i), peak_pulse, vt[i].epeak);
      chk($sformatf("v%0d_upd", i), update_done, vt[i].eupd);
      chk($sformatf("v%0d_ready", i), cfg.cfg_ready, vt[i].erdy);
      chk($sformatf("v%0d_fault", i), fault_active, 0);
      chk_comps($sformatf("v%0d", i), vt[i].ec1, vt[i].ec2);
    end
    drive(0, 0, 0, 0);

    step();
    chk("pre_fault_cnt", cnt, 2);
    fault_in = 1;
    repeat (3) step();
    chk("fault_brake", brake, 1);
    chk("fault_cnt", cnt, 0);
    chk("fault_dir", dir, 0);
    chk("fault_active", fault_active, 1);
    fault_clr = 1;
    step();
    fault_clr = 0;
    chk("clr_ignored", fault_active, 1);
    chk("clr_ignored_brake", brake, 1);
    fault_in = 0;
    repeat (2) step();
    chk("fault_held", fault_active, 1);
    fault_clr = 1;
    step();
    fault_clr = 0;
    chk("fault_exit", fault_active, 0);
    chk("exit_brake", brake, 1);
    step();
    chk("rerun_brake", brake, 0);
    chk("rerun_cnt", cnt, 0);
    chk("rerun_upd", update_done, 0);
    chk_comps("rerun", 3, 7);

    drive(1, 1, 1, 1);
    step();
    drive(0, 0, 0, 0);
    chk("b1_ready", cfg.cfg_ready, 0);
    repeat (7) step();
    chk("b1_early", update_done, 0);
    step();
    chk("b1_upd", update_done, 1);
    chk("b1_cnt", cnt, 1);
    chk_comps("b1", 1, 1);
    chk_seq("b1");

    drive(1, 0, 4, 4);
    step();
    drive(0, 0, 0, 0);
    chk("b0_ready", cfg.cfg_ready, 0);
    wait_upd("b0_upd");
    chk("b0_cnt", cnt, 1);
    chk_comps("b0", 4, 4);
    chk_seq("b0");

    drive(1, 5, 2, 2);
    step();
    drive(0, 0, 0, 0);
    chk("ar_ready_pre", cfg.cfg_ready, 0);
    #2 rstn = 0;
    #1;
    chk("ar_cnt", cnt, 0);
    chk("ar_dir", dir, 0);
    chk("ar_brake", brake, 1);
    chk("ar_ready", cfg.cfg_ready, 1);
    chk("ar_zero", zero_pulse, 0);
    chk("ar_peak", peak_pulse, 0);
    chk("ar_fault", fault_active, 0);
    chk_comps("ar", 0, 0);
    #3 rstn = 1;
    step();
    chk("ar_run_brake", brake, 0);
    chk("ar_run_upd", update_done, 0);
    chk_comps("ar_run", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
